// File: rtl/pe_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_link_pkg
// Brief    : Shared types, defaults and sizing helper for the PE link arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pe_link_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Default flit width, matching the PE link width
  localparam int DEFAULT_DATA_WIDTH = 130;

  // Width of an index able to address n requesters (at least one bit)
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_link_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first asserted request found
//            when searching from ptr upwards, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                any
);

  logic                found;
  logic [ID_WIDTH-1:0] idx;

  // Priority search starting at ptr; the first hit wins
  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_link_arbiter
// Brief    : Packet-aware round-robin arbiter sharing one PE link among
//            NUM_REQ requesters, with a single registered output stage,
//            ap_start-gated grants and forced release of overlong packets.
// Revision : 1.0 - initial release
// ============================================================================
module pe_link_arbiter
  import pe_link_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int MAX_FLITS  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ap_start,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy,
  output logic                            err_overlong
);

  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  state_e                state_q;
  logic [ID_WIDTH-1:0]   grant_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   rr_ptr_d;
  logic [CNT_W-1:0]      flit_cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  err_q;

  logic [ID_WIDTH-1:0]   arb_gnt;
  logic                  arb_any;
  logic                  stage_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  forced;
  logic                  release_pkt;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (arb_gnt),
    .any    (arb_any)
  );

  // Output stage can take a new flit when empty or draining this cycle
  assign stage_free = !out_valid_q || out_ready;

  // Select the grantee's lane and drive its ready; all other lanes stay low
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = (state_q == ST_BUSY) && stage_free;
      end
    end
  end

  assign accept      = (state_q == ST_BUSY) && stage_free && sel_valid;
  assign forced      = !sel_last && (flit_cnt_q == CNT_W'(MAX_FLITS - 1));
  assign release_pkt = accept && (sel_last || forced);
  assign rr_ptr_d    = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Grant FSM, flit counter, round-robin pointer and sticky overlong flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ap_start && arb_any) begin
            grant_q    <= arb_gnt;
            flit_cnt_q <= '0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            flit_cnt_q <= flit_cnt_q + 1'b1;
          end
          if (release_pkt) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= rr_ptr_d;
            if (forced) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered output stage: load on accept, drain when downstream takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last || forced;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == ST_BUSY);
  assign err_overlong = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_link_arbiter
// Brief    : Directed self-checking bench for pe_link_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_link_arbiter;

  localparam int NR = 4;
  localparam int DW = 130;
  localparam int IW = 2;
  localparam int MF = 4;

  logic              clk;
  logic              reset;
  logic              ap_start;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              err_overlong;

  int checks;
  int errors;
  int fidx [NR];
  int pkt  [NR];
  int plen [NR];

  pe_link_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .MAX_FLITS  (MF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ap_start     (ap_start),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_overlong (err_overlong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flit content: top bit set to exercise the full width, tagged by source/packet/index
  function automatic logic [DW-1:0] mk(input int s, input int p, input int f);
    logic [DW-1:0] v;
    v = '0;
    v[DW-1]  = 1'b1;
    v[23:16] = 8'(s);
    v[15:8]  = 8'(p);
    v[7:0]   = 8'(f);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present every source's current flit on its lane
  task automatic drive();
    for (int s = 0; s < NR; s++) begin
      req_data[s*DW +: DW] = mk(s, pkt[s], fidx[s]);
      req_last[s]          = (fidx[s] == plen[s] - 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int s = 0; s < NR; s++) begin
      fidx[s] = 0;
      pkt[s]  = 0;
      plen[s] = 2;
    end
    drive();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ap_start  = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    do_reset();
    checks++;
    if ({out_valid, out_last, busy, err_overlong} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {out_valid, out_last, busy, err_overlong});
    end
    checks++;
    if (out_data !== '0 || req_ready !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%0h ready=%b gid=%0d required 0/0000/0", out_data, req_ready, grant_id);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    plen[2]   = 3;
    ap_start  = 1'b1;
    req_valid = 4'b0100;
    drive();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_arb_ready: got %b required 0000", req_ready);
    end
    tick();
    checks++;
    if (grant_id !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got gid=%0d busy=%b ov=%b rdy=%b required 2/1/0/0100", grant_id, busy, out_valid, req_ready);
    end
    for (int f = 0; f < 3; f++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== mk(2, 0, f) || out_last !== (f == 2)) begin
        errors++;
        $display("FAIL single_flit%0d: got v=%b d=%0h l=%b required 1/%0h/%b", f, out_valid, out_data, out_last, mk(2, 0, f), (f == 2));
      end
      fidx[2] = f + 1;
      drive();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: got %b required 0", busy);
    end
    req_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_drain: got ov=%b gid=%0d required 0/2", out_valid, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    ap_start  = 1'b1;
    req_valid = 4'b1001;
    drive();
    for (int p = 0; p < 4; p++) begin
      g = (p % 2 == 0) ? 0 : 3;
      tick();
      checks++;
      if (grant_id !== IW'(g) || busy !== 1'b1 || req_ready !== NR'(1 << g)) begin
        errors++;
        $display("FAIL rr_grant%0d: got gid=%0d busy=%b rdy=%b required %0d/1/%b", p, grant_id, busy, req_ready, g, NR'(1 << g));
      end
      for (int f = 0; f < 2; f++) begin
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== mk(g, pkt[g], f) || out_last !== (f == 1)) begin
          errors++;
          $display("FAIL rr_pkt%0d_flit%0d: got v=%b d=%0h l=%b required 1/%0h/%b", p, f, out_valid, out_data, out_last, mk(g, pkt[g], f), (f == 1));
        end
        fidx[g] = (f == 1) ? 0 : 1;
        if (f == 1) pkt[g] = pkt[g] + 1;
        drive();
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    plen[1]   = 3;
    ap_start  = 1'b1;
    req_valid = 4'b0010;
    drive();
    tick();
    tick();
    fidx[1] = 1;
    drive();
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_ready_low: got %b required 0000", req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== mk(1, 0, 0) || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b d=%0h rdy=%b required 1/%0h/0000", c, out_valid, out_data, req_ready, mk(1, 0, 0));
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_ready_back: got %b required 0010", req_ready);
    end
    tick();
    checks++;
    if (out_data !== mk(1, 0, 1) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_flit1: got d=%0h l=%b required %0h/0", out_data, out_last, mk(1, 0, 1));
    end
    fidx[1] = 2;
    drive();
    tick();
    checks++;
    if (out_data !== mk(1, 0, 2) || out_last !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_flit2: got d=%0h l=%b busy=%b required %0h/1/0", out_data, out_last, busy, mk(1, 0, 2));
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_ap_start();
    do_reset();
    ap_start  = 1'b0;
    req_valid = 4'b0010;
    drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0000 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ap_gate%0d: got busy=%b rdy=%b ov=%b required 0/0000/0", c, busy, req_ready, out_valid);
      end
    end
    ap_start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL ap_grant: got busy=%b gid=%0d required 1/1", busy, grant_id);
    end
    ap_start = 1'b0;
    tick();
    fidx[1] = 1;
    drive();
    tick();
    checks++;
    if (out_data !== mk(1, 0, 1) || out_last !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ap_complete: got d=%0h l=%b busy=%b required %0h/1/0", out_data, out_last, busy, mk(1, 0, 1));
    end
    fidx[1] = 0;
    pkt[1]  = 1;
    drive();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL ap_no_regrant: got busy=%b rdy=%b required 0/0000", busy, req_ready);
    end
    ap_start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL ap_regrant: got busy=%b gid=%0d required 1/1", busy, grant_id);
    end
    req_valid = '0;
  endtask

  task automatic test_overlong_and_reset();
    do_reset();
    plen[0]   = 100;
    ap_start  = 1'b1;
    req_valid = 4'b0001;
    drive();
    tick();
    for (int f = 0; f < MF; f++) begin
      tick();
      checks++;
      if (out_data !== mk(0, 0, f) || out_last !== (f == MF - 1) || err_overlong !== (f == MF - 1)) begin
        errors++;
        $display("FAIL ovl_flit%0d: got d=%0h l=%b err=%b required %0h/%b/%b", f, out_data, out_last, err_overlong, mk(0, 0, f), (f == MF - 1), (f == MF - 1));
      end
      fidx[0] = f + 1;
      drive();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ovl_release: got busy=%b required 0", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || out_valid !== 1'b0 || err_overlong !== 1'b1) begin
      errors++;
      $display("FAIL ovl_rearb: got busy=%b gid=%0d ov=%b err=%b required 1/0/0/1", busy, grant_id, out_valid, err_overlong);
    end
    tick();
    checks++;
    if (out_data !== mk(0, 0, MF) || out_last !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovl_next: got d=%0h l=%b ov=%b required %0h/0/1", out_data, out_last, out_valid, mk(0, 0, MF));
    end
    // Reset while busy with a held output flit
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_last, busy, err_overlong} !== 4'b0000 || out_data !== '0 || req_ready !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL midreset: got ov=%b l=%b busy=%b err=%b d=%0h rdy=%b gid=%0d required all 0", out_valid, out_last, busy, err_overlong, out_data, req_ready, grant_id);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1001;
    tick();
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ptr: got gid=%0d busy=%b required 0/1", grant_id, busy);
    end
    req_valid = '0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    ap_start  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_ap_start();
    test_overlong_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the run ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pe_link_arbiter.md
Name: pe_link_arbiter

Overview:
- Round-robin, packet-aware arbiter sharing one PE link (e.g. the out_to_north channel of an overlay PE tile) among NUM_REQ upstream requesters.
- Grants one requester at a time and holds the grant until that requester's last flit.
- Forwards flits through a single registered output stage with a valid/ready handshake.
- ap_start gates new grants, matching the overlay PE start convention.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 130, flit width; matches the PE link width.
- ID_WIDTH, 2, width of grant index; must equal ceil(log2(NUM_REQ)).
- MAX_FLITS, 64, maximum flits per packet before a forced release.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ap_start  input  1  enables new grants; an in-flight packet always completes.
- req_valid  input  NUM_REQ  per-requester flit valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  last flit of packet.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- out_valid  output  1  registered flit valid.
- out_data  output  DATA_WIDTH  registered flit.
- out_last  output  1  registered last flag.
- out_ready  input  1  downstream accept.
- grant_id  output  ID_WIDTH  current or most recent grantee.
- busy  output  1  a packet is in flight (state BUSY).
- err_overlong  output  1  sticky; set on a forced release.

Behaviour:
- Reset (synchronous, active-high) clears state to IDLE. out_valid=0, out_data=0, out_last=0, req_ready=0, grant_id=0, busy=0, err_overlong=0, rr_ptr=0, flit_cnt=0.
- Reset asserted mid-packet: same clear next edge; any held output flit is dropped.
- States: IDLE, BUSY.
- IDLE: if ap_start and any req_valid, pick the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Registered: grant_id<=i, busy<=1, flit_cnt<=0, go to BUSY.
  - No data transfers in the arbitration cycle.
  - If ap_start=0, stay in IDLE with no grant.
- BUSY: req_ready[grant_id] = !out_valid || out_ready. This is combinational from registered state and out_ready. All other req_ready bits are 0.
- Accept = req_valid[g] && req_ready[g].
  - On accept: out_data<=flit, out_last<=req_last[g], out_valid<=1, flit_cnt++.
  - Else if out_ready: out_valid<=0.
  - Latency: a flit appears on out_* one cycle after it is accepted.
  - Throughput: one flit per cycle while out_ready stays high.
- End of packet: an accept with req_last[g]=1 sets state to IDLE, busy<=0, rr_ptr<=(g+1) mod NUM_REQ. The next grant can occur in the cycle after.
  - Minimum packet period is therefore (flits+1) cycles.
- Forced release: an accept with req_last=0 when flit_cnt==MAX_FLITS-1.
  - Forward the flit with out_last forced to 1.
  - err_overlong<=1, sticky until reset.
  - Release exactly as a normal last flit.
- ap_start deasserting in BUSY has no effect; the packet finishes.
- out_valid && !out_ready holds out_* stable; no accept occurs.
- grant_id retains its value after release.

Decomposition:
- Shared package pe_link_pkg holds:
  - state enum {IDLE, BUSY};
  - default DATA_WIDTH=130;
  - helper function for ID_WIDTH sizing.
- Sub-module rr_arbiter: combinational round-robin priority pick. Inputs req[NUM_REQ], ptr; outputs gnt_id, any.
- Top module holds the FSM, flit counter, output register and error flag.

Test Plan:
- Single packet: ap_start=1; req 2 sends 3 flits A1,A2,A3 (last on A3), out_ready=1 -> grant_id=2 after 1 cycle; out_data A1,A2,A3 on consecutive cycles; out_last only with A3; busy falls after A3 is accepted.
- Round robin: reqs 0 and 3 both hold 2-flit packets continuously -> grant order 0,3,0,3; rr_ptr=1 after req 0 and 0 after req 3; no flits interleave.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data stays at flit 1; req_ready[g]=0 while out_valid=1; flit 2 appears the cycle after out_ready=1.
- ap_start gating: ap_start=0 with req 1 valid -> no grant, req_ready=0. Drop ap_start mid-packet -> packet completes; no new grant until ap_start=1.
- Overlong: MAX_FLITS=4; req 0 streams 6 flits without last -> the 4th flit is output with out_last=1; err_overlong=1; then a new arbitration occurs.
- Reset mid-packet: assert reset while BUSY with out_valid=1 -> next cycle all outputs 0, state IDLE, rr_ptr=0.
